// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared constants for the ALU arbiter: ALU control codes,
//               word constants, arbiter FSM state encodings and an op-code
//               legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_OFF = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Word constants
  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;
  localparam logic [31:0] WORD_ONE  = 32'h0000_0001;
  localparam logic [31:0] Z         = 32'hzzzz_zzzz;

  // Arbiter FSM state encodings
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_EXEC = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_e;

  // True for the five codes the ALU actually implements
  function automatic logic alu_op_legal(input logic [2:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
      default:                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational 32-bit ALU (AND, OR, ADD, SUB, signed SLT)
//               with a zero flag. Unsupported control codes produce zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero
);
  import alu_arbiter_pkg::*;

  // Result select; ADD/SUB wrap, SLT compares as two's complement
  always_comb begin
    y = '0;
    case (ctrl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = ($signed(a) < $signed(b)) ? WORD_ONE : WORD_ZERO;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU between two requesters (0 = execute path,
//               1 = address/PC path). IDLE grants and latches one operation,
//               EXEC runs the ALU and captures the result, RESP pulses the
//               tagged response for one cycle.
//               Macro ALU_ARB_RR_EN: defined = round-robin arbitration,
//               undefined = fixed priority to requester 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [2:0]       r0_op,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [2:0]       r1_op,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);
  import alu_arbiter_pkg::*;

  // The datapath and its constants are 32-bit only
  generate
    if (WIDTH != 32) begin : g_width_check
      $error("alu_arbiter: only WIDTH = 32 is supported");
    end
  endgenerate

  arb_state_e       state;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic [2:0]       lat_op;
  logic             lat_id;

  logic             grant0;
  logic             grant1;
  logic             in_idle;
  logic             accept;

  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             op_legal;

`ifdef ALU_ARB_RR_EN
  // Pointer high means requester 1 wins a tie
  logic rr_ptr;

  assign grant1 = r1_valid && (!r0_valid || rr_ptr);

  // After each grant, favour the requester that was not served
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= !grant1;
    end
  end
`else
  // Requester 1 only gets through when requester 0 is idle
  assign grant1 = r1_valid && !r0_valid;
`endif

  assign grant0  = r0_valid && !grant1;

  // Ready only in IDLE outside reset, and only to the winner
  assign in_idle  = (state == ARB_IDLE) && !rst;
  assign r0_ready = in_idle && grant0;
  assign r1_ready = in_idle && grant1;
  assign accept   = in_idle && (grant0 || grant1);

  // The ALU sees the latched operation only in EXEC; elsewhere it is parked
  always_comb begin
    alu_ctrl = ALU_OFF;
    alu_a    = '0;
    alu_b    = '0;
    if (state == ARB_EXEC) begin
      alu_ctrl = lat_op;
      alu_a    = lat_a;
      alu_b    = lat_b;
    end
  end

  // Legality is decided here, so an illegal code never lets ALU output through
  assign op_legal = alu_op_legal(lat_op);

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .ctrl (alu_ctrl),
    .a    (alu_a),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Arbiter FSM: latch on handshake, capture result in EXEC, pulse in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      busy      <= 1'b0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_op    <= ALU_OFF;
      lat_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (accept) begin
            lat_a  <= grant1 ? r1_a  : r0_a;
            lat_b  <= grant1 ? r1_b  : r0_b;
            lat_op <= grant1 ? r1_op : r0_op;
            lat_id <= grant1;
            busy   <= 1'b1;
            state  <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          if (op_legal) begin
            rsp_y    <= alu_y;
            rsp_zero <= alu_zero;
            rsp_err  <= 1'b0;
          end else begin
            rsp_y    <= WORD_ZERO;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b1;
          end
          rsp_id    <= lat_id;
          rsp_valid <= 1'b1;
          busy      <= 1'b1;
          state     <= ARB_RESP;
        end
        ARB_RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ARB_IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed bench for alu_arbiter with an expected-response
//               queue. Contention expectations follow ALU_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    logic        id;
    logic [31:0] y;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid;
  logic        r0_ready, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]  r0_op, r1_op;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_err, busy;
  logic [31:0] rsp_y;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   prev_rsp_cyc = 0;
  bit   have_prev = 0;
  bit   spacing_chk = 0;
  exp_t sb[$];

  // Contention stimulus and per-requester expected results
  logic [2:0]  c0_op [4] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR};
  logic [31:0] c0_a  [4] = '{32'h1, 32'h5, 32'hF0, 32'h0};
  logic [31:0] c0_b  [4] = '{32'h2, 32'h7, 32'hFF, 32'h0};
  logic [31:0] c0_y  [4] = '{32'h3, 32'hFFFF_FFFE, 32'hF0, 32'h0};
  logic [2:0]  c1_op [4] = '{ALU_ADD, ALU_SLT, ALU_OR, ALU_SUB};
  logic [31:0] c1_a  [4] = '{32'hFFFF_FFFF, 32'h3, 32'hA, 32'h0};
  logic [31:0] c1_b  [4] = '{32'h1, 32'h5, 32'h5, 32'h1};
  logic [31:0] c1_y  [4] = '{32'h0, 32'h1, 32'hF, 32'hFFFF_FFFF};

  alu_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r0_op     (r0_op),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .r1_op     (r1_op),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input logic id, input logic [31:0] y, input logic zero, input logic err);
    exp_t e;
    e.id = id; e.y = y; e.zero = zero; e.err = err;
    sb.push_back(e);
  endtask

  // Response monitor: pops the scoreboard and checks fields and timing
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {31'b0, rsp_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("rsp_id",   {31'b0, rsp_id},   {31'b0, e.id});
        check("rsp_y",    rsp_y,             e.y);
        check("rsp_zero", {31'b0, rsp_zero}, {31'b0, e.zero});
        check("rsp_err",  {31'b0, rsp_err},  {31'b0, e.err});
        check("latency",  32'(cyc - hs_cyc), 32'd2);
        if (spacing_chk && have_prev)
          check("spacing", 32'(cyc - prev_rsp_cyc), 32'd3);
        prev_rsp_cyc = cyc;
        have_prev    = 1;
      end
    end
  end

  task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 0;
    @(posedge clk); #1;
    if (id) begin r1_valid = 1; r1_op = op; r1_a = a; r1_b = b; end
    else    begin r0_valid = 1; r0_op = op; r0_a = a; r0_b = b; end
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (id ? r1_ready : r0_ready) begin
        hs_cyc = cyc;
        done   = 1;
      end
    end
    if (!done) check("handshake_timeout", {31'b0, done}, 32'h1);
    @(posedge clk); #1;
    r0_valid = 0;
    r1_valid = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int i0, i1;
    bit a0, a1, saw;

    // Reset with both valids high: readys must stay low
    rst = 1; r0_valid = 1; r1_valid = 1;
    r0_op = ALU_ADD; r0_a = 32'h1; r0_b = 32'h1;
    r1_op = ALU_ADD; r1_a = 32'h2; r1_b = 32'h2;
    repeat (3) @(negedge clk);
    check("reset_r0_ready",  {31'b0, r0_ready},  32'h0);
    check("reset_r1_ready",  {31'b0, r1_ready},  32'h0);
    check("reset_busy",      {31'b0, busy},      32'h0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rsp_y",     rsp_y,              32'h0);
    check("reset_rsp_flags", {29'b0, rsp_id, rsp_zero, rsp_err}, 32'h0);
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 0; rst = 0;

    // Single request: ADD 8 + 0x29
    expect_rsp(1'b0, 32'h31, 1'b0, 1'b0);
    issue(1'b0, ALU_ADD, 32'h8, 32'h29);
    check("exec_busy",     {31'b0, busy},     32'h1);
    check("exec_r0_ready", {31'b0, r0_ready}, 32'h0);
    drain();

    // Zero flag from requester 1
    expect_rsp(1'b1, 32'h0, 1'b1, 1'b0);
    issue(1'b1, ALU_SUB, 32'h8, 32'h8);
    drain();

    // Signed SLT
    expect_rsp(1'b0, 32'h0, 1'b1, 1'b0);
    issue(1'b0, ALU_SLT, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
    expect_rsp(1'b0, 32'h1, 1'b0, 1'b0);
    issue(1'b0, ALU_SLT, 32'hFFFF_FFFB, 32'hFFFF_FFFD);
    expect_rsp(1'b0, 32'h0, 1'b1, 1'b0);
    issue(1'b0, ALU_SLT, 32'h1, 32'hFFFF_FFFF);
    drain();

    // Illegal op from requester 1 (also leaves the RR pointer favouring 0)
    expect_rsp(1'b1, 32'h0, 1'b0, 1'b1);
    issue(1'b1, ALU_OFF, 32'h5, 32'h5);
    drain();

    // Contention: both requesters hold valid with four ops each
`ifdef ALU_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      expect_rsp(1'b0, c0_y[k], c0_y[k] == 32'h0, 1'b0);
      expect_rsp(1'b1, c1_y[k], c1_y[k] == 32'h0, 1'b0);
    end
`else
    for (int k = 0; k < 4; k++) expect_rsp(1'b0, c0_y[k], c0_y[k] == 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) expect_rsp(1'b1, c1_y[k], c1_y[k] == 32'h0, 1'b0);
`endif
    spacing_chk = 1; have_prev = 0;
    i0 = 0; i1 = 0;
    @(posedge clk); #1;
    r0_valid = 1; r0_op = c0_op[0]; r0_a = c0_a[0]; r0_b = c0_b[0];
    r1_valid = 1; r1_op = c1_op[0]; r1_a = c1_a[0]; r1_b = c1_b[0];
    for (int k = 0; k < 60 && (i0 < 4 || i1 < 4); k++) begin
      @(negedge clk);
      a0 = r0_valid && r0_ready;
      a1 = r1_valid && r1_ready;
      if (a0 || a1) hs_cyc = cyc;
      @(posedge clk); #1;
      if (a0) begin
        i0++;
        if (i0 < 4) begin r0_op = c0_op[i0]; r0_a = c0_a[i0]; r0_b = c0_b[i0]; end
        else r0_valid = 0;
      end
      if (a1) begin
        i1++;
        if (i1 < 4) begin r1_op = c1_op[i1]; r1_a = c1_a[i1]; r1_b = c1_b[i1]; end
        else r1_valid = 0;
      end
    end
    r0_valid = 0; r1_valid = 0;
    check("contention_count", 32'(i0 + i1), 32'd8);
    drain();
    spacing_chk = 0;

    // Reset asserted in EXEC aborts the operation
    issue(1'b0, ALU_ADD, 32'h2, 32'h3);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    saw = 0;
    @(negedge clk);
    check("abort_rsp_y",     rsp_y, 32'h0);
    check("abort_rsp_flags", {28'b0, busy, rsp_id, rsp_zero, rsp_err}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) saw = 1;
      @(negedge clk);
    end
    check("abort_no_rsp", {31'b0, saw}, 32'h0);

    // Next request after the abort is served normally
    expect_rsp(1'b1, 32'h0000_0FF0, 1'b0, 1'b0);
    issue(1'b1, ALU_OR, 32'h0000_0F00, 32'h0000_00F0);
    drain();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit in case the DUT stalls somewhere unexpected
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
